// File: rtl/mod_n_wrap_tracker.sv
// Watches an upstream mod-N count and reports each N-1 -> 0 wrap. Wraps are
// counted modulo M. Any illegal step latches a sticky fault until clr or rst.
module mod_n_wrap_tracker #(
  parameter int N      = 10,
  parameter int WIDTH  = 4,
  parameter int M      = 6,
  parameter int CWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              clr,
  output logic              wrap_pulse,
  output logic [CWIDTH-1:0] wrap_cnt,
  output logic              carry,
  output logic              err
);

  typedef enum logic [1:0] {EMPTY, TRACK, FAULT} state_t;

  localparam logic [WIDTH:0]    NW   = N[WIDTH:0];
  localparam logic [WIDTH-1:0]  TOP  = WIDTH'(N - 1);
  localparam logic [CWIDTH-1:0] CTOP = CWIDTH'(M - 1);

  state_t           state;
  logic [WIDTH-1:0] prev;

  logic in_range, is_hold, is_step, is_wrap, legal;

  // Comparisons run one bit wider so prev+1 cannot alias back to 0.
  always_comb begin
    in_range = ({1'b0, cnt_in} < NW);
    is_hold  = (cnt_in == prev);
    is_step  = (prev != TOP) && ({1'b0, cnt_in} == ({1'b0, prev} + 1'b1));
    is_wrap  = (prev == TOP) && (cnt_in == '0);
    legal    = in_range && (is_hold || is_step || is_wrap);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      prev       <= '0;
      wrap_cnt   <= '0;
      wrap_pulse <= 1'b0;
      carry      <= 1'b0;
      err        <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      carry      <= 1'b0;
      if (clr) begin
        state    <= EMPTY;
        prev     <= '0;
        wrap_cnt <= '0;
        err      <= 1'b0;
      end else begin
        case (state)
          EMPTY: if (en) begin
            prev <= cnt_in;
            if (in_range) begin
              state <= TRACK;
            end else begin
              state <= FAULT;
              err   <= 1'b1;
            end
          end
          TRACK: if (en) begin
            prev <= cnt_in;
            if (!legal) begin
              state <= FAULT;
              err   <= 1'b1;
            end else if (is_wrap) begin
              wrap_pulse <= 1'b1;
              if (wrap_cnt == CTOP) begin
                wrap_cnt <= '0;
                carry    <= 1'b1;
              end else begin
                wrap_cnt <= wrap_cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= FAULT;
            err   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
